// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: operand forwarding selects, long-latency register scoreboard,
// stall/flush generation and redirect bubbles. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int FWD_DEPTH        = 2,
  parameter int REG_W            = 5,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [FWD_DEPTH-1:0]       fwd_valid,
  input  logic [FWD_DEPTH*REG_W-1:0] fwd_rd,
  input  logic [REG_W-1:0]           exec_rs1,
  input  logic [REG_W-1:0]           exec_rs2,
  output logic [FWD_DEPTH-1:0]       fwd_sel_rs1,
  output logic [FWD_DEPTH-1:0]       fwd_sel_rs2,
  input  logic                       dec_valid,
  input  logic [REG_W-1:0]           dec_rs1,
  input  logic [REG_W-1:0]           dec_rs2,
  input  logic                       exec_mem2reg,
  input  logic [REG_W-1:0]           exec_rd,
  input  logic                       issue_long,
  input  logic [REG_W-1:0]           issue_rd,
  input  logic                       retire_valid,
  input  logic [REG_W-1:0]           retire_rd,
  input  logic                       bra,
  input  logic                       jmp,
  input  logic                       ifetch_valid,
  input  logic                       dmem_valid,
  output logic                       fetch_stall,
  output logic                       exec_stall,
  output logic                       exec_flush,
  output logic                       mem_flush,
  output logic                       sb_busy,
  output logic                       sb_err,
  output logic [31:0]                stall_cnt,
  output logic [31:0]                flush_cnt
);

  localparam int NREG = 1 << REG_W;
  localparam logic [2:0] BUB_LOAD = 3'(REDIRECT_BUBBLES - 1);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_eff;
  logic [2:0]      r_bubble;
  logic            r_err;
  logic            w_raw, w_waw, w_load, w_redirect;
  logic            w_hit1, w_hit2;

  // Lowest-index (youngest) matching source wins.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    w_hit1      = 1'b0;
    w_hit2      = 1'b0;
    for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
      if (!w_hit1 && fwd_valid[k] && exec_rs1 != '0 &&
          fwd_rd[k*REG_W +: REG_W] == exec_rs1) begin
        fwd_sel_rs1[k] = 1'b1;
        w_hit1         = 1'b1;
      end
      if (!w_hit2 && fwd_valid[k] && exec_rs2 != '0 &&
          fwd_rd[k*REG_W +: REG_W] == exec_rs2) begin
        fwd_sel_rs2[k] = 1'b1;
        w_hit2         = 1'b1;
      end
    end
  end

  // A writeback retiring this cycle already resolves the hazard.
  always_comb begin
    w_eff = r_pending;
    if (retire_valid) w_eff[retire_rd] = 1'b0;
  end

  always_comb begin
    w_raw       = dec_valid && ((dec_rs1 != '0 && w_eff[dec_rs1]) ||
                                (dec_rs2 != '0 && w_eff[dec_rs2]));
    w_waw       = issue_long && w_eff[issue_rd];
    w_load      = exec_mem2reg && exec_rd != '0 &&
                  (exec_rd == dec_rs1 || exec_rd == dec_rs2);
    exec_stall  = !dmem_valid;
    mem_flush   = exec_stall;
    fetch_stall = !ifetch_valid || exec_stall || w_raw || w_waw || w_load;
    w_redirect  = (bra || jmp) && !exec_stall;
    exec_flush  = w_redirect || (r_bubble != '0) || (fetch_stall && !exec_stall);
    sb_busy     = |r_pending;
    sb_err      = r_err;
  end

  // Issue is applied after retire so a same-register collision leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_err     <= 1'b0;
    end else begin
      if (retire_valid) begin
        if (!r_pending[retire_rd]) r_err <= 1'b1;
        r_pending[retire_rd] <= 1'b0;
      end
      if (issue_long && issue_rd != '0 && !exec_stall) r_pending[issue_rd] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_bubble <= '0;
    else if (w_redirect)                r_bubble <= BUB_LOAD;
    else if (r_bubble != '0 && !exec_stall) r_bubble <= r_bubble - 3'd1;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (fetch_stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (exec_flush && r_flush_cnt != '1)  r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios then randomized traffic
// compared against a behavioural model of the hazard rules.
module tb_hazard_scoreboard;

  localparam int FWD  = 2;
  localparam int RW   = 5;
  localparam int RB   = 3;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [FWD-1:0]  fwd_valid;
  logic [FWD*RW-1:0] fwd_rd;
  logic [RW-1:0]   exec_rs1, exec_rs2, dec_rs1, dec_rs2, exec_rd, issue_rd, retire_rd;
  logic [FWD-1:0]  fwd_sel_rs1, fwd_sel_rs2;
  logic            dec_valid, exec_mem2reg, issue_long, retire_valid;
  logic            bra, jmp, ifetch_valid, dmem_valid;
  logic            fetch_stall, exec_stall, exec_flush, mem_flush, sb_busy, sb_err;
  logic [31:0]     stall_cnt, flush_cnt;

  hazard_scoreboard #(.FWD_DEPTH(FWD), .REG_W(RW), .REDIRECT_BUBBLES(RB)) dut (
    .clk(clk), .rst(rst), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .exec_rs1(exec_rs1), .exec_rs2(exec_rs2),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .exec_mem2reg(exec_mem2reg), .exec_rd(exec_rd),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .bra(bra), .jmp(jmp), .ifetch_valid(ifetch_valid), .dmem_valid(dmem_valid),
    .fetch_stall(fetch_stall), .exec_stall(exec_stall), .exec_flush(exec_flush),
    .mem_flush(mem_flush), .sb_busy(sb_busy), .sb_err(sb_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model state
  bit          m_pend[NREG];
  bit          m_err;
  int          m_bub;
  logic [31:0] m_sc, m_fc;

  function automatic bit eff(input int r);
    return m_pend[r] && !(retire_valid && int'(retire_rd) == r);
  endfunction

  function automatic logic [FWD-1:0] fsel(input logic [RW-1:0] rs);
    logic [FWD-1:0] s = '0;
    if (rs == 0) return s;
    for (int i = 0; i < FWD; i++) begin
      logic [RW-1:0] d;
      d = fwd_rd[i*RW +: RW];
      if (fwd_valid[i] && d == rs) begin
        s[i] = 1'b1;
        return s;
      end
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    m_err = 1'b0; m_bub = 0; m_sc = 0; m_fc = 0;
  endtask

  // Compare every output with the model, then advance the model by one clock.
  task automatic tick();
    bit raw, waw, ld, est, fst, redir, fl, busy;
    #1;
    if (rst) model_clear();
    raw   = dec_valid && ((dec_rs1 != 0 && eff(int'(dec_rs1))) || (dec_rs2 != 0 && eff(int'(dec_rs2))));
    waw   = issue_long && eff(int'(issue_rd));
    ld    = exec_mem2reg && exec_rd != 0 && (exec_rd == dec_rs1 || exec_rd == dec_rs2);
    est   = !dmem_valid;
    fst   = !ifetch_valid || est || raw || waw || ld;
    redir = (bra || jmp) && !est;
    fl    = redir || m_bub > 0 || (fst && !est);
    busy  = 1'b0;
    for (int r = 0; r < NREG; r++) busy |= m_pend[r];
    check("fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(fsel(exec_rs1)));
    check("fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(fsel(exec_rs2)));
    check("exec_stall", 32'(exec_stall), 32'(est));
    check("mem_flush", 32'(mem_flush), 32'(est));
    check("fetch_stall", 32'(fetch_stall), 32'(fst));
    check("exec_flush", 32'(exec_flush), 32'(fl));
    check("sb_busy", 32'(sb_busy), 32'(busy));
    check("sb_err", 32'(sb_err), 32'(m_err));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
`else
    check("stall_cnt", stall_cnt, 32'd0);
    check("flush_cnt", flush_cnt, 32'd0);
`endif
    if (!rst) begin
      if (retire_valid) begin
        if (!m_pend[retire_rd]) m_err = 1'b1;
        m_pend[retire_rd] = 1'b0;
      end
      if (issue_long && issue_rd != 0 && !est) m_pend[issue_rd] = 1'b1;
      if (redir) m_bub = RB - 1;
      else if (m_bub > 0 && !est) m_bub--;
      if (fst && m_sc != 32'hFFFFFFFF) m_sc++;
      if (fl && m_fc != 32'hFFFFFFFF) m_fc++;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; fwd_valid = '0; fwd_rd = '0; exec_rs1 = '0; exec_rs2 = '0;
    dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; exec_mem2reg = 1'b0; exec_rd = '0;
    issue_long = 1'b0; issue_rd = '0; retire_valid = 1'b0; retire_rd = '0;
    bra = 1'b0; jmp = 1'b0; ifetch_valid = 1'b1; dmem_valid = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int nfl;

  initial begin
    model_clear();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset_busy", 32'(sb_busy), 32'd0);
    check("reset_err", 32'(sb_err), 32'd0);
    check("reset_flush", 32'(exec_flush), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;

    // Forwarding priority and register 0
    fwd_valid = 2'b11; fwd_rd = {5'd5, 5'd5}; exec_rs1 = 5'd5;
    #1 check("fwd_youngest", 32'(fwd_sel_rs1), 32'h1);
    tick();
    exec_rs1 = 5'd0;
    #1 check("fwd_r0", 32'(fwd_sel_rs1), 32'h0);
    tick();
    idle_inputs();

    // Long-latency RAW with same-cycle writeback bypass
    issue_long = 1'b1; issue_rd = 5'd7;
    tick();
    idle_inputs();
    dec_valid = 1'b1; dec_rs2 = 5'd7;
    #1 check("raw_stall", 32'(fetch_stall), 32'd1);
    retire_valid = 1'b1; retire_rd = 5'd7;
    #1 check("raw_bypass", 32'(fetch_stall), 32'd0);
    tick();
    idle_inputs();
    #1 check("busy_cleared", 32'(sb_busy), 32'd0);
    tick();

    // Issue wins over retire on the same register; stray retire sets sticky error
    issue_long = 1'b1; issue_rd = 5'd9;
    tick();
    retire_valid = 1'b1; retire_rd = 5'd9;
    tick();
    idle_inputs();
    dec_valid = 1'b1; dec_rs1 = 5'd9;
    #1 check("issue_wins", 32'(fetch_stall), 32'd1);
    check("issue_wins_err", 32'(sb_err), 32'd0);
    tick();
    idle_inputs();
    retire_valid = 1'b1; retire_rd = 5'd3;
    tick();
    idle_inputs();
    #1 check("sb_err_set", 32'(sb_err), 32'd1);
    tick();
    #1 check("sb_err_sticky", 32'(sb_err), 32'd1);
    tick();
    do_reset();

    // Redirect bubbles
    bra = 1'b1;
    nfl = 0;
    #1 nfl += int'(exec_flush);
    tick();
    bra = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 nfl += int'(exec_flush);
      tick();
    end
    check("redirect_bubbles", 32'(nfl), 32'd3);
    bra = 1'b1; dmem_valid = 1'b0;
    #1 check("redirect_stalled_flush", 32'(exec_flush), 32'd0);
    check("redirect_stalled_memflush", 32'(mem_flush), 32'd1);
    tick();
    idle_inputs();

    // Load-use
    exec_mem2reg = 1'b1; exec_rd = 5'd0; dec_rs1 = 5'd0;
    #1 check("load_r0_stall", 32'(fetch_stall), 32'd0);
    tick();
    exec_rd = 5'd4; dec_rs1 = 5'd4;
    #1 check("load_use_stall", 32'(fetch_stall), 32'd1);
    check("load_use_flush", 32'(exec_flush), 32'd1);
    tick();
    idle_inputs();

    // Performance counters and asynchronous reset
    do_reset();
    ifetch_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    idle_inputs();
`ifdef HAZARD_PERF_CNT_EN
    #1 check("stall_cnt_10", stall_cnt, 32'd10);
`else
    #1 check("stall_cnt_off", stall_cnt, 32'd0);
`endif
    #1 rst = 1'b1;
    #1 check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);
    tick();
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom % 60) == 0;
      fwd_valid    = FWD'($urandom);
      fwd_rd       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      exec_rs1     = 5'($urandom_range(0, 7));
      exec_rs2     = 5'($urandom_range(0, 7));
      dec_valid    = ($urandom % 4) != 0;
      dec_rs1      = 5'($urandom_range(0, 7));
      dec_rs2      = 5'($urandom_range(0, 7));
      exec_mem2reg = ($urandom % 6) == 0;
      exec_rd      = 5'($urandom_range(0, 7));
      issue_long   = ($urandom % 4) == 0;
      issue_rd     = 5'($urandom_range(0, 7));
      retire_rd    = 5'($urandom_range(1, 7));
      retire_valid = (($urandom % 3) == 0) && (m_pend[retire_rd] || ($urandom % 16) == 0);
      bra          = ($urandom % 8) == 0;
      jmp          = ($urandom % 12) == 0;
      ifetch_valid = ($urandom % 8) != 0;
      dmem_valid   = ($urandom % 6) != 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
